pc_unit: RTL and testbench



---
 rtl/mips_pkg.sv | 21 ++
 rtl/pc_unit_if.sv | 34 +++
 rtl/pc_pend_buf.sv | 33 +++
 rtl/pc_unit.sv | 89 ++++++++
 tb/tb_pc_unit.sv | 127 ++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_pkg
// Purpose  : Constants shared by the MIPS core blocks: fetch vectors, the
//            legal instruction-memory window and CP0 exception codes.
// Revision : 1.0 - initial release
// ============================================================================
package mips_pkg;

  localparam logic [31:0] RESET_VEC = 32'h0000_3000;
  localparam logic [31:0] EXC_VEC   = 32'h0000_4180;
  localparam logic [31:0] IMEM_BASE = 32'h0000_3000;
  localparam logic [31:0] IMEM_LAST = 32'h0000_6FFC;

  // ExcCode reported by CP0 for an address error on load or instruction fetch
  localparam logic [4:0]  EXC_ADEL  = 5'd4;

  localparam int unsigned INSTR_BYTES = 4;

endpackage : mips_pkg
`default_nettype wire

// File: rtl/pc_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : pc_unit_if
// Purpose  : Control and status bundle between the pipeline and the fetch
//            program counter. The pipeline side is the master.
// Revision : 1.0 - initial release
// ============================================================================
interface pc_unit_if #(
  parameter int ADDR_W = 32
) ();

  logic              stall;
  logic              br_valid;
  logic [ADDR_W-1:0] br_target;
  logic              exc_req;
  logic              eret_req;
  logic [ADDR_W-1:0] epc;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_plus4;
  logic              adel;
  logic              redirect_pending;

  modport master (
    output stall, br_valid, br_target, exc_req, eret_req, epc,
    input  pc, pc_plus4, adel, redirect_pending
  );

  modport slave (
    input  stall, br_valid, br_target, exc_req, eret_req, epc,
    output pc, pc_plus4, adel, redirect_pending
  );

endinterface : pc_unit_if
`default_nettype wire

// File: rtl/pc_pend_buf.sv
`default_nettype none
// ============================================================================
// Module   : pc_pend_buf
// Purpose  : One-entry valid+target holding register for a redirect that
//            arrives while fetch is stalled. Capture overwrites any older
//            entry; clear empties the entry and takes precedence.
// Revision : 1.0 - initial release
// ============================================================================
module pc_pend_buf #(
  parameter int ADDR_W = 32
) (
  input  wire logic              clk,
  input  wire logic              reset,
  input  wire logic              capture,
  input  wire logic              clear,
  input  wire logic [ADDR_W-1:0] din,
  output logic                   valid,
  output logic [ADDR_W-1:0]      target
);

  // Entry update: reset/clear empty it, capture loads (or overwrites) it
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      valid  <= 1'b0;
      target <= '0;
    end else if (capture) begin
      valid  <= 1'b1;
      target <= din;
    end
  end

endmodule : pc_pend_buf
`default_nettype wire

// File: rtl/pc_unit.sv
`default_nettype none
// ============================================================================
// Module   : pc_unit
// Purpose  : Fetch-stage program counter. Next PC is chosen by priority:
//            exception, ERET, stall (hold, buffering any redirect), live
//            redirect, buffered redirect, sequential. Also flags fetch
//            address errors for the current PC.
// Revision : 1.0 - initial release
// ============================================================================
module pc_unit #(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(mips_pkg::RESET_VEC),
  parameter logic [ADDR_W-1:0] EXC_VEC   = ADDR_W'(mips_pkg::EXC_VEC),
  parameter logic [ADDR_W-1:0] IMEM_BASE = ADDR_W'(mips_pkg::IMEM_BASE),
  parameter logic [ADDR_W-1:0] IMEM_LAST = ADDR_W'(mips_pkg::IMEM_LAST)
) (
  input  wire logic  clk,
  input  wire logic  reset,
  pc_unit_if.slave   bus
);

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(mips_pkg::INSTR_BYTES);

  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_plus4;
  logic [ADDR_W-1:0] w_next_pc;
  logic              w_capture;
  logic              w_clear;
  logic              w_pend_valid;
  logic [ADDR_W-1:0] w_pend_target;

  // Sequential successor wraps naturally modulo 2^ADDR_W
  assign w_pc_plus4 = r_pc + STEP;

  // Next-PC priority mux and pending-buffer control
  always_comb begin
    w_next_pc = w_pc_plus4;
    w_capture = 1'b0;
    w_clear   = 1'b0;
    if (bus.exc_req) begin
      w_next_pc = EXC_VEC;
      w_clear   = 1'b1;
    end else if (bus.eret_req) begin
      w_next_pc = bus.epc;
      w_clear   = 1'b1;
    end else if (bus.stall) begin
      // Hold fetch; a redirect seen now must survive until the stall lifts
      w_next_pc = r_pc;
      w_capture = bus.br_valid;
    end else if (bus.br_valid) begin
      // A live redirect is newer than anything buffered
      w_next_pc = bus.br_target;
      w_clear   = 1'b1;
    end else if (w_pend_valid) begin
      w_next_pc = w_pend_target;
      w_clear   = 1'b1;
    end
  end

  // Program counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc <= RESET_VEC;
    end else begin
      r_pc <= w_next_pc;
    end
  end

  pc_pend_buf #(
    .ADDR_W (ADDR_W)
  ) u_pend_buf (
    .clk     (clk),
    .reset   (reset),
    .capture (w_capture),
    .clear   (w_clear),
    .din     (bus.br_target),
    .valid   (w_pend_valid),
    .target  (w_pend_target)
  );

  assign bus.pc               = r_pc;
  assign bus.pc_plus4         = w_pc_plus4;
  assign bus.redirect_pending = w_pend_valid;
  // Misaligned or outside the instruction memory window (unsigned compares)
  assign bus.adel             = (r_pc[1:0] != 2'b00) | (r_pc < IMEM_BASE) |
                                (r_pc > IMEM_LAST);

endmodule : pc_unit
`default_nettype wire

// File: tb/tb_pc_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_unit
// Purpose  : Directed self-checking bench for pc_unit with an expected-value
//            scoreboard queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_unit;

  typedef struct {
    logic [31:0] pc;
    logic        pend;
    logic        adel;
    string       tag;
  } exp_t;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;
  exp_t sb[$];

  pc_unit_if #(.ADDR_W(32)) bus ();

  pc_unit #(.ADDR_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus, queue its expectation, then score it after the edge
  task automatic step(input logic rs, input logic st, input logic bv,
                      input logic [31:0] bt, input logic ex, input logic er,
                      input logic [31:0] ep, input logic [31:0] e_pc,
                      input logic e_pend, input logic e_adel, input string tag);
    exp_t e;
    @(negedge clk);
    reset         = rs;
    bus.stall     = st;
    bus.br_valid  = bv;
    bus.br_target = bt;
    bus.exc_req   = ex;
    bus.eret_req  = er;
    bus.epc       = ep;
    e.pc   = e_pc;
    e.pend = e_pend;
    e.adel = e_adel;
    e.tag  = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $error("FAIL %s scoreboard empty observed=%h expected=entry", tag, bus.pc);
    end else begin
      e = sb.pop_front();
      check({e.tag, ".pc"},       bus.pc,                      e.pc);
      check({e.tag, ".pc_plus4"}, bus.pc_plus4,                e.pc + 32'd4);
      check({e.tag, ".adel"},     {31'd0, bus.adel},             {31'd0, e.adel});
      check({e.tag, ".pend"},     {31'd0, bus.redirect_pending}, {31'd0, e.pend});
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset = 1'b1;
    bus.stall = 1'b0; bus.br_valid = 1'b0; bus.br_target = '0;
    bus.exc_req = 1'b0; bus.eret_req = 1'b0; bus.epc = '0;

    //   rs st bv target        ex er epc           exp pc        pend adel tag
    // Reset and sequential fetch
    step(1, 0, 0, 32'h0,        0, 0, 32'h0,        32'h0000_3000, 0, 0, "rst0");
    step(1, 0, 1, 32'h5000,     1, 0, 32'h0,        32'h0000_3000, 0, 0, "rst1");
    step(0, 0, 0, 32'h0,        0, 0, 32'h0,        32'h0000_3004, 0, 0, "seq1");
    step(0, 0, 0, 32'h0,        0, 0, 32'h0,        32'h0000_3008, 0, 0, "seq2");
    step(0, 0, 0, 32'h0,        0, 0, 32'h0,        32'h0000_300C, 0, 0, "seq3");
    step(0, 0, 0, 32'h0,        0, 0, 32'h0,        32'h0000_3010, 0, 0, "seq4");
    // Redirect captured during stall, replayed on release
    step(0, 1, 1, 32'h3400,     0, 0, 32'h0,        32'h0000_3010, 1, 0, "stcap");
    step(0, 1, 0, 32'h0,        0, 0, 32'h0,        32'h0000_3010, 1, 0, "sthold1");
    step(0, 1, 0, 32'h0,        0, 0, 32'h0,        32'h0000_3010, 1, 0, "sthold2");
    step(0, 0, 0, 32'h0,        0, 0, 32'h0,        32'h0000_3400, 0, 0, "replay");
    // Overwrite, then a live request beats the buffered one
    step(0, 1, 1, 32'h3400,     0, 0, 32'h0,        32'h0000_3400, 1, 0, "ow1");
    step(0, 1, 1, 32'h3500,     0, 0, 32'h0,        32'h0000_3400, 1, 0, "ow2");
    step(0, 0, 1, 32'h3600,     0, 0, 32'h0,        32'h0000_3600, 0, 0, "livewin");
    step(0, 1, 1, 32'h3400,     0, 0, 32'h0,        32'h0000_3600, 1, 0, "ow3");
    step(0, 1, 1, 32'h3500,     0, 0, 32'h0,        32'h0000_3600, 1, 0, "ow4");
    step(0, 0, 0, 32'h0,        0, 0, 32'h0,        32'h0000_3500, 0, 0, "newest");
    // Exception beats ERET, stall and a pending redirect
    step(0, 1, 1, 32'h3700,     0, 0, 32'h0,        32'h0000_3500, 1, 0, "precap");
    step(0, 1, 1, 32'h3800,     1, 1, 32'h3002,     32'h0000_4180, 0, 0, "exc");
    step(0, 0, 0, 32'h0,        0, 0, 32'h0,        32'h0000_4184, 0, 0, "postexc");
    // ERET and the fetch address-error window
    step(0, 0, 1, 32'h3400,     0, 1, 32'h3002,     32'h0000_3002, 0, 1, "eret_mis");
    step(0, 1, 0, 32'h0,        0, 1, 32'h7000,     32'h0000_7000, 0, 1, "eret_hi");
    step(0, 0, 0, 32'h0,        0, 1, 32'h6FFC,     32'h0000_6FFC, 0, 0, "eret_last");
    step(0, 0, 0, 32'h0,        0, 0, 32'h0,        32'h0000_7000, 0, 1, "past_last");
    step(0, 0, 0, 32'h0,        0, 1, 32'h2FFC,     32'h0000_2FFC, 0, 1, "below_base");
    step(0, 0, 0, 32'h0,        0, 0, 32'h0,        32'h0000_3000, 0, 0, "at_base");
    // Wraparound
    step(0, 0, 1, 32'hFFFF_FFFC, 0, 0, 32'h0,       32'hFFFF_FFFC, 0, 1, "wraptop");
    step(0, 0, 0, 32'h0,        0, 0, 32'h0,        32'h0000_0000, 0, 1, "wrap0");
    // Reset drops a pending redirect with no replay
    step(0, 1, 1, 32'h3400,     0, 0, 32'h0,        32'h0000_0000, 1, 1, "pendrst");
    step(1, 0, 0, 32'h0,        0, 0, 32'h0,        32'h0000_3000, 0, 0, "rstdrop");
    step(0, 0, 0, 32'h0,        0, 0, 32'h0,        32'h0000_3004, 0, 0, "noreplay");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_pc_unit
`default_nettype wire
